// File: rtl/prefetch_unit_pkg.sv
// Shared types for the instruction prefetch path.
// Address/data widths plus the prefetch queue sizing.
package common_types;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
  typedef logic [2:0]  pf_count_t;

  localparam int PF_DEPTH = 4;

endpackage

// File: rtl/prefetch_unit_if.sv
// Program-memory read bus between prefetch and memory.
// Memory returns data the cycle after a sampled request.
interface prefetch_unit_if;
  import common_types::*;

  logic  mem_rd;
  addr_t mem_addr;
  data_t mem_rdata;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/prefetch_unit_fifo.sv
// Circular byte buffer with multi-byte pop and 3-entry peek.
// Peek outputs are zero beyond the valid count.
module pf_fifo
  import common_types::*;
#(
  parameter int DEPTH = PF_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      wr,
  input  data_t     wdata,
  input  logic [1:0] pop,
  output pf_count_t count,
  output data_t     b0,
  output data_t     b1,
  output data_t     b2
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;

  data_t mem_q [DEPTH];
  ptr_t  rp;
  ptr_t  wp;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem_q[wp] <= wdata;
        wp        <= wp + ptr_t'(1);
      end
      rp    <= rp + ptr_t'(pop);
      count <= count - pf_count_t'(pop)
             + pf_count_t'(wr);
    end
  end

  always_comb begin
    b0 = '0;
    b1 = '0;
    b2 = '0;
    if (count >= 3'd1) b0 = mem_q[rp];
    if (count >= 3'd2) b1 = mem_q[rp + ptr_t'(1)];
    if (count >= 3'd3) b2 = mem_q[rp + ptr_t'(2)];
  end

endmodule

// File: rtl/prefetch_unit.sv
// Sequential instruction-byte prefetcher feeding the CPU decoder.
// Credit-based fetch keeps queued plus in-flight bytes within DEPTH.
module prefetch_unit
  import common_types::*;
#(
  parameter int    DEPTH    = PF_DEPTH,
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       redirect,
  input  addr_t      redirect_pc,
  input  logic [1:0] consume,
  output pf_count_t  avail,
  output data_t      b0,
  output data_t      b1,
  output data_t      b2,
  output addr_t      head_pc,
  prefetch_unit_if.master mem
);

  pf_count_t  count;
  logic       rsp_q;
  logic [1:0] drop_q;
  logic [1:0] drop_d;
  addr_t      fa_q;
  addr_t      fa_d;
  addr_t      pc_q;
  addr_t      pc_d;
  addr_t      addr_d;
  addr_t      base;
  logic       req_d;
  logic       wr;
  logic [1:0] pop;
  logic [3:0] cnt_nx;

  always_comb begin
    pop    = (3'(consume) > count) ? count[1:0] : consume;
    wr     = rsp_q && (drop_q == 2'd0);
    drop_d = drop_q;
    if (rsp_q && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
    cnt_nx = 4'(count) - 4'(pop) + 4'(wr);
    base   = fa_q;
    pc_d   = pc_q + addr_t'(pop);
    // Only the request sampled at this edge is still to come back stale.
    if (redirect) begin
      cnt_nx = '0;
      base   = redirect_pc;
      pc_d   = redirect_pc;
      drop_d = 2'(mem.mem_rd);
    end
    req_d  = (cnt_nx + 4'(mem.mem_rd) + 4'd1) <= 4'(DEPTH);
    addr_d = req_d ? base : mem.mem_addr;
    fa_d   = req_d ? base + 16'd1 : base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= RESET_PC;
      rsp_q        <= 1'b0;
      drop_q       <= 2'd0;
      fa_q         <= RESET_PC;
      pc_q         <= RESET_PC;
    end else begin
      mem.mem_rd   <= req_d;
      mem.mem_addr <= addr_d;
      rsp_q        <= mem.mem_rd;
      drop_q       <= drop_d;
      fa_q         <= fa_d;
      pc_q         <= pc_d;
    end
  end

  pf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect),
    .wr    (wr),
    .wdata (mem.mem_rdata),
    .pop   (pop),
    .count (count),
    .b0    (b0),
    .b1    (b1),
    .b2    (b2)
  );

  assign avail   = count;
  assign head_pc = pc_q;

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: vector table, corner sequences, random run.
// Reference: bytes shown are always mem[head_pc + i] for i < avail.
module tb_prefetch_unit;
  import common_types::*;

  localparam addr_t RPC = 16'h0000;

  logic       clk;
  logic       rst_n;
  logic       redirect;
  addr_t      rpc;
  logic [1:0] consume;
  pf_count_t  avail;
  data_t      b0, b1, b2;
  addr_t      head_pc;

  prefetch_unit_if bus();

  prefetch_unit #(
    .DEPTH(4),
    .RESET_PC(RPC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (rpc),
    .consume     (consume),
    .avail       (avail),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .head_pc     (head_pc),
    .mem         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic data_t memv(addr_t a);
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_rdata <= memv(bus.mem_addr);

  always @(negedge clk)
    if (rst_n === 1'b1 && redirect === 1'b0)
      assert (consume <= avail)
      else $error("consume above avail");

  int    n_cmp = 0;
  int    n_bad = 0;
  addr_t mpc;
  int    prev_av;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    int lo;
    int hi;
    prev_av = int'(avail);
    @(posedge clk);
    #1;
    if (!rst_n) mpc = RPC;
    else if (redirect) mpc = rpc;
    else mpc = mpc + addr_t'(consume);
    chk("head_pc", head_pc, mpc);
    if (!rst_n || redirect) begin
      chk("avail_flush", avail, 0);
    end else begin
      lo = prev_av - int'(consume);
      hi = (lo + 1 > 4) ? 4 : lo + 1;
      chk("avail_range",
          (int'(avail) >= lo && int'(avail) <= hi), 1);
    end
    chk("b0", b0, (avail > 0) ? memv(mpc) : 8'h00);
    chk("b1", b1, (avail > 1) ? memv(mpc + 16'd1) : 8'h00);
    chk("b2", b2, (avail > 2) ? memv(mpc + 16'd2) : 8'h00);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    consume  = 2'd0;
    rpc      = 16'h0000;
    step();
    step();
    chk("rst_avail", avail, 0);
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_addr", bus.mem_addr, RPC);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rdi;
    addr_t      rpc;
    logic [1:0] cons;
    int         av;
    logic       rd;
    addr_t      addr;
    addr_t      pc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b0, 16'h0, 2'd0, 0, 1'b1, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0, 2'd0, 0, 1'b1, 16'h0001, 16'h0000};
    tbl[2]  = '{1'b0, 16'h0, 2'd0, 1, 1'b1, 16'h0002, 16'h0000};
    tbl[3]  = '{1'b0, 16'h0, 2'd0, 2, 1'b1, 16'h0003, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0, 2'd0, 3, 1'b0, 16'h0003, 16'h0000};
    tbl[5]  = '{1'b0, 16'h0, 2'd0, 4, 1'b0, 16'h0003, 16'h0000};
    tbl[6]  = '{1'b0, 16'h0, 2'd0, 4, 1'b0, 16'h0003, 16'h0000};
    tbl[7]  = '{1'b1, 16'hFFFE, 2'd0, 0, 1'b1, 16'hFFFE, 16'hFFFE};
    tbl[8]  = '{1'b0, 16'h0, 2'd0, 0, 1'b1, 16'hFFFF, 16'hFFFE};
    tbl[9]  = '{1'b0, 16'h0, 2'd0, 1, 1'b1, 16'h0000, 16'hFFFE};
    tbl[10] = '{1'b0, 16'h0, 2'd1, 1, 1'b1, 16'h0001, 16'hFFFF};
    tbl[11] = '{1'b0, 16'h0, 2'd1, 1, 1'b1, 16'h0002, 16'h0000};
    tbl[12] = '{1'b0, 16'h0, 2'd1, 1, 1'b1, 16'h0003, 16'h0001};

    mpc = RPC;
    do_reset();
    chk("rst_pc", head_pc, RPC);

    for (int i = 0; i < 13; i++) begin
      redirect = tbl[i].rdi;
      rpc      = tbl[i].rpc;
      consume  = tbl[i].cons;
      step();
      chk($sformatf("v%0d_avail", i), avail, tbl[i].av);
      chk($sformatf("v%0d_rd", i), bus.mem_rd, tbl[i].rd);
      chk($sformatf("v%0d_addr", i), bus.mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_pc", i), head_pc, tbl[i].pc);
      if (i == 5) begin
        chk("t1_b0", b0, 8'hA5);
        chk("t1_b1", b1, 8'hA4);
        chk("t1_b2", b2, 8'hA7);
      end
    end
    redirect = 1'b0;
    chk("t4_b0_last", b0, 8'hA4);

    consume = 2'd0;
    for (int i = 0; i < 6; i++) step();
    chk("fill_avail", avail, 4);
    for (int i = 0; i < 6; i++) begin
      consume = (avail >= 2) ? 2'd2 : 2'(avail);
      step();
    end
    consume = 2'd0;

    do_reset();
    step();
    step();
    redirect = 1'b1;
    rpc      = 16'h0123;
    step();
    redirect = 1'b0;
    chk("t3_rd", bus.mem_rd, 1);
    chk("t3_addr", bus.mem_addr, 16'h0123);
    step();
    chk("t3_avail_r1", avail, 0);
    step();
    chk("t3_avail_r2", avail, 1);
    chk("t3_b0", b0, 8'h86);
    step();
    step();
    chk("t3_avail_r4", avail, 3);

    rst_n = 1'b0;
    step();
    chk("t6_avail", avail, 0);
    chk("t6_pc", head_pc, RPC);
    chk("t6_rd", bus.mem_rd, 0);
    rst_n = 1'b1;
    step();
    chk("t6_avail_a", avail, 0);
    chk("t6_rd_a", bus.mem_rd, 1);
    chk("t6_addr_a", bus.mem_addr, RPC);
    step();
    chk("t6_avail_b", avail, 0);
    step();
    chk("t6_avail_c", avail, 1);
    chk("t6_b0", b0, 8'hA5);

    redirect = 1'b1;
    rpc      = 16'h0010;
    step();
    rpc = 16'h0040;
    step();
    redirect = 1'b0;
    chk("t5_addr", bus.mem_addr, 16'h0040);
    step();
    chk("t5_avail_a", avail, 0);
    step();
    chk("t5_avail_b", avail, 1);
    chk("t5_b0", b0, 8'hE5);

    for (int i = 0; i < 400; i++) begin
      redirect = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFD
                                        : 16'($urandom);
      consume = 2'($urandom_range(0, (avail > 3) ? 3 : int'(avail)));
      step();
    end
    redirect = 1'b0;
    consume  = 2'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Instruction-byte prefetch queue sitting directly upstream of the CPU unit, between program memory and the CPU.
- Streams sequential bytes from a synchronous-read memory into a small byte FIFO.
- Presents the next three bytes (opcode plus up to two operands) and their address to the CPU. The CPU then decodes without addressing memory itself.
- The CPU consumes 1–3 bytes per instruction, or redirects the stream on JMP or a taken branch.

Parameters:
- DEPTH, 4: FIFO capacity in bytes; power of two, at least 3.
- RESET_PC, 16'h0000: fetch and head address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  16 (addr_t)  new stream address.
- consume  in  2  bytes removed from the head this cycle (0–3).
- avail  out  3  valid bytes in the queue (0..DEPTH).
- b0  out  8 (data_t)  head byte; 8'h00 when avail < 1.
- b1  out  8 (data_t)  second byte; 8'h00 when avail < 2.
- b2  out  8 (data_t)  third byte; 8'h00 when avail < 3.
- head_pc  out  16 (addr_t)  address of b0.
- mem_rd  out  1  read request; registered output.
- mem_addr  out  16 (addr_t)  read address; registered output.
- mem_rdata  in  8 (data_t)  data valid in the cycle after a cycle with mem_rd=1.

Behaviour:
- Reset (rst_n=0 at an edge):
  - avail=0, b0..b2=0, head_pc=RESET_PC, fetch address=RESET_PC.
  - mem_rd=0, mem_addr=RESET_PC, pending=0, drop count=0.
  - Reset mid-stream discards all queued and in-flight bytes; a response arriving the cycle after reset is ignored.
- Memory timing:
  - At edge E, with mem_rd=1, the memory samples mem_addr.
  - mem_rdata is valid in the following cycle and is written into the FIFO at edge E+1.
- Pending and credit:
  - pending counts requests issued but not yet written; its maximum is 2.
  - Invariant: count + pending <= DEPTH at all times.
  - A new request is registered whenever the post-edge count plus pending permits it.
- Steady-state throughput is 1 byte per cycle.
- Each issued request registers mem_addr <= fetch address, then fetch address += 1. Address arithmetic is mod 2^16: 16'hFFFF wraps to 16'h0000.
- Normal edge (no redirect):
  - count_next = count - consume + wr, where wr = 1 if a non-dropped response arrives.
  - Consume and write in the same cycle are both applied.
  - head_pc += consume, mod 2^16.
  - Full FIFO with consume=0: no write is lost, because the credit rule prevents issuing into a full FIFO.
- consume > avail is a protocol error:
  - The design clamps consume to avail.
  - The bench asserts that it never occurs.
- Redirect (takes priority over consume):
  - FIFO cleared (avail=0 next cycle); head_pc and fetch address <= redirect_pc.
  - Drop count <= number of in-flight requests; those responses are discarded on arrival.
  - mem_rd=1 with mem_addr=redirect_pc in the next cycle.
  - First byte valid (avail=1) two cycles after the redirect edge; avail=3 after four.
- Redirect during an outstanding drop:
  - Drop count is reloaded from the current in-flight count.
  - Stale bytes must never reach b0..b2.
- Redirect together with rst_n=0: reset wins.
- b0..b2 are combinational views of the FIFO head entries, masked by avail.

Decomposition:
- In package common_types:
  - Reuse addr_t and data_t.
  - Add a pf_count_t typedef (3 bits) and a PF_DEPTH constant.
- One sub-module, pf_fifo: a circular byte buffer.
  - Write port, multi-byte pop (0–3), clear input.
  - Read pointer, write pointer and count.
  - Three-entry peek output.
- prefetch_unit keeps the request, pending, drop-count and address logic.

Test Plan:
- Memory model for all scenarios: mem[a] = a[7:0] ^ 8'hA5.
1. Reset, then run with consume=0 -> mem_addr sequence 0,1,2,3; avail reaches 4 and holds; mem_rd stays low afterwards; b0..b2=A5,A4,A7; head_pc=0.
2. Full queue, then consume=2 each cycle for 6 cycles -> head_pc advances by 2 per cycle; b0 always equals mem[head_pc]; no byte skipped or duplicated; avail never exceeds 4 or underflows.
3. Redirect to 16'h0123 while 2 requests are in flight -> avail=0 next cycle; mem_addr=0123 the cycle after the redirect edge; avail=1 two cycles after the redirect edge with b0=86; the stale bytes never appear.
4. Redirect to 16'hFFFE, consume 1 per cycle -> head_pc sequence FFFE, FFFF, 0000, 0001; b0 sequence 5B, 5A, A5, A4.
5. Back-to-back redirects to 0010 then 0040 on consecutive cycles -> first valid b0=E5 (mem[0040]); no byte from 0010 or from before the redirects is ever presented.
6. rst_n=0 for one cycle mid-stream with avail=3 -> next cycle avail=0, head_pc=RESET_PC, mem_rd=0; the response in flight at the reset edge is not written.
